ttc_prescale_tick_lite: RTL and testbench
=========================================

Name: ttc_prescale_tick_lite

Overview:
- Clock-enable generator for one TTC timer channel.
- Sits directly downstream of the channel's clock-control/counter-reset stage. Consumes that stage's 7-bit clock control value and its count enable.
- Produces a single-cycle count tick that the interval/overflow counter uses to advance.
- Selects pclk or a synchronised external clock as the tick source, and optionally divides that source by a power-of-two prescaler.

Parameters:
- PS_WIDTH, 16, width of the prescale counter. Maximum division is 2^PS_WIDTH.
- SYNC_STAGES, 2, number of flops in the ext_clk synchroniser. Legal values are 2 or more.

Ports:
- pclk  input  1  APB system clock; the only clock.
- n_p_reset  input  1  asynchronous active-low reset.
- count_en  input  1  counter enable from the counter-reset stage. It is low for one cycle at each restart.
- clk_ctrl_reg  input  7  clock control value.
  - [0] ps_en
  - [4:1] ps_v
  - [5] ext_sel
  - [6] ext_edge: 0 = rising, 1 = falling
- ext_clk  input  1  external clock, asynchronous to pclk. Its high and low phases are each at least 2 pclk periods.
- cnt_tick  output  1  registered one-cycle count enable to the counter.
- ps_cnt_out  output  PS_WIDTH  current prescale count, for debug/readback.

Behaviour:
- Reset (asynchronous, n_p_reset low):
  - All synchroniser flops and the edge-history flop clear to 0.
  - ps_cnt clears to 0.
  - cnt_tick clears to 0.
  - Hence ps_cnt_out = 0.
- Synchroniser:
  - ext_clk passes through SYNC_STAGES flops to give s_ext.
  - Each cycle, prev_ext <= s_ext.
  - The synchroniser and prev_ext run every cycle regardless of count_en or clk_ctrl_reg.
- Source pulse src (combinational):
  - ext_sel = 0: src = 1.
  - ext_sel = 1, ext_edge = 0: src = s_ext & ~prev_ext.
  - ext_sel = 1, ext_edge = 1: src = ~s_ext & prev_ext.
- Divider value: div = 2^(ps_v+1), giving 2..65536 for ps_v 0..15. If ps_v+1 > PS_WIDTH, div = 2^PS_WIDTH.
- Per-cycle update, first matching rule wins:
  1. count_en = 0: ps_cnt <= 0; cnt_tick <= 0.
  2. ps_en = 0: ps_cnt <= 0; cnt_tick <= src.
  3. src = 1 and ps_cnt >= div-1: ps_cnt <= 0; cnt_tick <= 1.
  4. src = 1: ps_cnt <= ps_cnt+1; cnt_tick <= 0.
  5. Otherwise: hold ps_cnt; cnt_tick <= 0.
- Comparison uses >=. If ps_v is reduced mid-count below the current ps_cnt, the next src produces a tick and the counter clears. No wrap through 2^PS_WIDTH is ever taken.
- Latency:
  - Internal source: cnt_tick is high the cycle after count_en first samples high.
  - External source: an ext_clk edge produces cnt_tick SYNC_STAGES+1 pclk edges later (3 at default).
- Tick period with ps_en = 1: exactly div src pulses per tick. The first tick after count_en rises needs a full div pulses, because ps_cnt starts at 0.
- Restart: the one-cycle count_en low clears ps_cnt and suppresses any tick in that cycle. A src pulse landing in that cycle is dropped, not deferred.
- Changing ext_sel or ext_edge never creates a spurious edge by itself; only a real s_ext transition of the selected polarity creates one.
- clk_ctrl_reg changes take effect on the next pclk edge. There is no shadowing.
- cnt_tick is never high for two consecutive cycles when ps_en = 1 or ext_sel = 1, given the legal ext_clk rate.

Test Plan:
- Reset then count_en = 1, clk_ctrl_reg = 7'h00 -> cnt_tick = 0 during reset; cnt_tick high every cycle from the cycle after count_en rises; ps_cnt_out stays 0.
- clk_ctrl_reg = 7'h05 (ps_en = 1, ps_v = 2, div = 8), internal source -> first tick on the 8th cycle of counting; then exactly 1 tick per 8 cycles; ps_cnt_out cycles 0..7.
- clk_ctrl_reg = 7'h20 (ext rising, no prescale), ext_clk period 10 pclk -> exactly one cnt_tick per ext_clk period, 3 cycles after each rising edge. Then set 7'h60 -> ticks move to falling edges with no extra tick at the switch.
- clk_ctrl_reg = 7'h1F (ps_v = 15, div = 65536), internal source -> first tick after 65536 cycles. Then change to 7'h03 (div = 4) while ps_cnt_out = 100 -> tick on the next cycle and ps_cnt_out returns to 0.
- Div-8 running, drop count_en low for 1 cycle when ps_cnt_out = 5 -> no tick in the low cycle; ps_cnt_out = 0; next tick 8 cycles after count_en returns high.
- Assert n_p_reset low mid-count with ps_cnt_out = 3 and an ext edge in flight in the synchroniser -> all outputs 0 immediately (asynchronous); no tick after release until a fresh source edge/count.

Source files
------------

// File: rtl/ttc_prescale_tick_lite_if.sv
// Channel-side bundle for the TTC tick generator: control inputs coming from
// the clock-control/counter-reset stage plus the tick and debug count going
// back out to the interval/overflow counter.
interface ttc_prescale_tick_lite_if #(
    parameter int PS_WIDTH = 16
);
    logic                count_en;
    logic [6:0]          clk_ctrl_reg;
    logic                ext_clk;
    logic                cnt_tick;
    logic [PS_WIDTH-1:0] ps_cnt_out;

    // Upstream control stage / bench side
    modport master (
        output count_en,
        output clk_ctrl_reg,
        output ext_clk,
        input  cnt_tick,
        input  ps_cnt_out
    );

    // Tick generator side
    modport slave (
        input  count_en,
        input  clk_ctrl_reg,
        input  ext_clk,
        output cnt_tick,
        output ps_cnt_out
    );
endinterface

// File: rtl/ttc_prescale_tick_lite.sv
// Count-enable generator for one TTC timer channel. Selects pclk or a
// synchronised external clock edge as the source pulse, optionally divides it
// by 2^(ps_v+1), and emits a registered single-cycle cnt_tick.
module ttc_prescale_tick_lite #(
    parameter int PS_WIDTH    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    pclk,
    input  logic                    n_p_reset,
    ttc_prescale_tick_lite_if.slave bus
);

    // Terminal count (div-1) as a mask: bits 0..ps_v set, saturating at
    // all-ones when ps_v+1 exceeds the counter width.
    function automatic logic [PS_WIDTH-1:0] div_term(input logic [3:0] ps_v);
        logic [PS_WIDTH-1:0] m;
        m = {PS_WIDTH{1'b0}};
        for (int i = 0; i < PS_WIDTH; i++) begin
            m[i] = ($unsigned(i) <= {28'd0, ps_v});
        end
        return m;
    endfunction

    logic                   ps_en_s;
    logic [3:0]             ps_v_s;
    logic                   ext_sel_s;
    logic                   ext_edge_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_ext_s;
    logic                   prev_ext_r;
    logic                   src_s;
    logic [PS_WIDTH-1:0]    div_term_s;
    logic [PS_WIDTH-1:0]    ps_cnt_r;
    logic                   tick_r;

    assign ps_en_s    = bus.clk_ctrl_reg[0];
    assign ps_v_s     = bus.clk_ctrl_reg[4:1];
    assign ext_sel_s  = bus.clk_ctrl_reg[5];
    assign ext_edge_s = bus.clk_ctrl_reg[6];
    assign s_ext_s    = sync_r[SYNC_STAGES-1];
    assign div_term_s = div_term(ps_v_s);

    // Synchroniser and edge history run free so an ext_sel/ext_edge change
    // only ever sees real transitions, never a stale history value.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            sync_r     <= {SYNC_STAGES{1'b0}};
            prev_ext_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[SYNC_STAGES-2:0], bus.ext_clk};
            prev_ext_r <= s_ext_s;
        end
    end

    // Source pulse: every pclk, or one cycle per selected external edge.
    always_comb begin
        src_s = 1'b1;
        if (ext_sel_s) begin
            if (ext_edge_s) begin
                src_s = ~s_ext_s & prev_ext_r;
            end else begin
                src_s = s_ext_s & ~prev_ext_r;
            end
        end else begin
            src_s = 1'b1;
        end
    end

    // Prescale counter and tick; >= compare means a shrinking divider
    // terminates the current period rather than wrapping the counter.
    always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
            ps_cnt_r <= {PS_WIDTH{1'b0}};
            tick_r   <= 1'b0;
        end else if (!bus.count_en) begin
            ps_cnt_r <= {PS_WIDTH{1'b0}};
            tick_r   <= 1'b0;
        end else if (!ps_en_s) begin
            ps_cnt_r <= {PS_WIDTH{1'b0}};
            tick_r   <= src_s;
        end else if (src_s && (ps_cnt_r >= div_term_s)) begin
            ps_cnt_r <= {PS_WIDTH{1'b0}};
            tick_r   <= 1'b1;
        end else if (src_s) begin
            ps_cnt_r <= ps_cnt_r + {{(PS_WIDTH-1){1'b0}}, 1'b1};
            tick_r   <= 1'b0;
        end else begin
            ps_cnt_r <= ps_cnt_r;
            tick_r   <= 1'b0;
        end
    end

    assign bus.cnt_tick   = tick_r;
    assign bus.ps_cnt_out = ps_cnt_r;

endmodule

// File: tb/tb_ttc_prescale_tick_lite.sv
// Directed bench for ttc_prescale_tick_lite: internal/external sources,
// divide-by-8 cadence, maximum divider, divider shrink, restart and async reset.
module tb_ttc_prescale_tick_lite;

    logic pclk;
    logic n_p_reset;
    int   n_cmp;
    int   n_err;
    int   n_ticks;
    logic exp_tick;

    ttc_prescale_tick_lite_if #(.PS_WIDTH(16)) bus ();

    ttc_prescale_tick_lite #(
        .PS_WIDTH    (16),
        .SYNC_STAGES (2)
    ) dut (
        .pclk      (pclk),
        .n_p_reset (n_p_reset),
        .bus       (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled and inputs driven 1 ns later.
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic cyc_n(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        n_p_reset = 1'b0;
        bus.count_en = 1'b0;
        bus.clk_ctrl_reg = 7'h00;
        bus.ext_clk = 1'b0;

        // Reset state
        cyc_n(3);
        check_val("rst_tick", {31'd0, bus.cnt_tick}, 32'd0);
        check_val("rst_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        n_p_reset = 1'b1;
        cyc();
        bus.count_en = 1'b1;
        check_val("int_pre_tick", {31'd0, bus.cnt_tick}, 32'd0);

        // Internal source, no prescale: tick every cycle
        for (int c = 1; c <= 5; c++) begin
            cyc();
            check_val("int_tick", {31'd0, bus.cnt_tick}, 32'd1);
            check_val("int_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        end

        // Divide by 8
        bus.count_en = 1'b0;
        cyc();
        check_val("rs_tick", {31'd0, bus.cnt_tick}, 32'd0);
        bus.count_en = 1'b1;
        bus.clk_ctrl_reg = 7'h05;
        for (int c = 1; c <= 24; c++) begin
            cyc();
            check_val("d8_tick", {31'd0, bus.cnt_tick}, ((c % 8) == 0) ? 32'd1 : 32'd0);
            check_val("d8_ps", {16'd0, bus.ps_cnt_out}, 32'(c % 8));
        end

        // Restart while ps_cnt_out = 5
        cyc_n(5);
        check_val("rst5_ps", {16'd0, bus.ps_cnt_out}, 32'd5);
        bus.count_en = 1'b0;
        cyc();
        check_val("restart_tick", {31'd0, bus.cnt_tick}, 32'd0);
        check_val("restart_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        bus.count_en = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            check_val("after_rs_tick", {31'd0, bus.cnt_tick}, (c == 8) ? 32'd1 : 32'd0);
            check_val("after_rs_ps", {16'd0, bus.ps_cnt_out}, 32'(c % 8));
        end

        // External rising then falling, ext_clk period 10 pclk (5 high / 5 low)
        for (int t = 0; t < 70; t++) begin
            if (t == 0)  bus.clk_ctrl_reg = 7'h20;
            if (t == 40) bus.clk_ctrl_reg = 7'h60;
            bus.ext_clk = ((t % 10) < 5) ? 1'b1 : 1'b0;
            cyc();
            if (t < 40) exp_tick = ((t >= 2) && ((t % 10) == 2));
            else        exp_tick = ((t % 10) == 7);
            check_val(t < 40 ? "ext_rise_tick" : "ext_fall_tick",
                      {31'd0, bus.cnt_tick}, {31'd0, exp_tick});
        end
        bus.ext_clk = 1'b0;

        // Maximum divider: first tick after 65536 cycles
        bus.count_en = 1'b0;
        cyc();
        bus.count_en = 1'b1;
        bus.clk_ctrl_reg = 7'h1F;
        n_ticks = 0;
        for (int c = 1; c <= 65535; c++) begin
            cyc();
            if (bus.cnt_tick) n_ticks++;
        end
        check_val("d64k_early_ticks", 32'(n_ticks), 32'd0);
        check_val("d64k_ps_max", {16'd0, bus.ps_cnt_out}, 32'd65535);
        cyc();
        check_val("d64k_tick", {31'd0, bus.cnt_tick}, 32'd1);
        check_val("d64k_ps_wrap", {16'd0, bus.ps_cnt_out}, 32'd0);

        // Shrink divider below the running count
        cyc_n(100);
        check_val("shrink_ps100", {16'd0, bus.ps_cnt_out}, 32'd100);
        check_val("shrink_pre_tick", {31'd0, bus.cnt_tick}, 32'd0);
        bus.clk_ctrl_reg = 7'h03;
        cyc();
        check_val("shrink_tick", {31'd0, bus.cnt_tick}, 32'd1);
        check_val("shrink_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            check_val("d4_tick", {31'd0, bus.cnt_tick}, (c == 4) ? 32'd1 : 32'd0);
        end

        // Async reset with ps_cnt_out = 3 and an ext edge in the synchroniser
        bus.count_en = 1'b0;
        cyc();
        bus.count_en = 1'b1;
        bus.clk_ctrl_reg = 7'h25;
        for (int k = 0; k < 3; k++) begin
            bus.ext_clk = 1'b1;
            cyc_n(5);
            bus.ext_clk = 1'b0;
            cyc_n(5);
        end
        check_val("pre_rst_ps3", {16'd0, bus.ps_cnt_out}, 32'd3);
        bus.ext_clk = 1'b1;
        cyc();
        #2;
        n_p_reset = 1'b0;
        #1;
        check_val("async_rst_tick", {31'd0, bus.cnt_tick}, 32'd0);
        check_val("async_rst_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        bus.ext_clk = 1'b0;
        cyc_n(2);
        n_p_reset = 1'b1;
        n_ticks = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (bus.cnt_tick) n_ticks++;
        end
        check_val("post_rst_ticks", 32'(n_ticks), 32'd0);
        check_val("post_rst_ps", {16'd0, bus.ps_cnt_out}, 32'd0);
        bus.ext_clk = 1'b1;
        cyc_n(3);
        check_val("fresh_edge_ps", {16'd0, bus.ps_cnt_out}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
